id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the RISC-V core, directly upstream of the ALU. It captures decoded instruction fields at the end of ID. In EX it resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, then presents `secA`, `secB` and the 3-bit ALU control to the ALU. It supports stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle of stall/flush control, ID-stage fields, writeback producer
// inputs and EX-stage outputs for the ID/EX pipeline stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_alu_src;
    logic            id_a_pc;
    logic [2:0]      id_alu_ctrl;
    logic            id_reg_write;
    logic [RA_W-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [RA_W-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_secA;
    logic [XLEN-1:0] ex_secB;
    logic [2:0]      ex_alu_ctrl;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic [1:0]      ex_fwd_a;
    logic [1:0]      ex_fwd_b;

    modport master (
        output stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_alu_src, id_a_pc, id_alu_ctrl, id_reg_write,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  ex_valid, ex_secA, ex_secB, ex_alu_ctrl, ex_store_data,
               ex_rd, ex_reg_write, ex_fwd_a, ex_fwd_b
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_alu_src, id_a_pc, id_alu_ctrl, id_reg_write,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output ex_valid, ex_secA, ex_secB, ex_alu_ctrl, ex_store_data,
               ex_rd, ex_reg_write, ex_fwd_a, ex_fwd_b
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Registers decoded fields, resolves rs1/rs2 hazards combinationally and
// drives the ALU operand muxes. Supports stall (hold) and flush (bubble).
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            alu_src;
        logic            a_pc;
        logic [2:0]      alu_ctrl;
        logic            reg_write;
    } fields_t;

    fields_t         ex_q;
    fields_t         id_fields;
    logic [XLEN-1:0] fwd_a_val;
    logic [XLEN-1:0] fwd_b_val;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;

    // Gather ID-stage fields; an invalid ID slot becomes an all-zero bubble
    always_comb begin
        id_fields = '0;
        if (bus.id_valid) begin
            id_fields.valid     = 1'b1;
            id_fields.pc        = bus.id_pc;
            id_fields.imm       = bus.id_imm;
            id_fields.rs1_data  = bus.id_rs1_data;
            id_fields.rs2_data  = bus.id_rs2_data;
            id_fields.rs1       = bus.id_rs1;
            id_fields.rs2       = bus.id_rs2;
            id_fields.rd        = bus.id_rd;
            id_fields.alu_src   = bus.id_alu_src;
            id_fields.a_pc      = bus.id_a_pc;
            id_fields.alu_ctrl  = bus.id_alu_ctrl;
            id_fields.reg_write = bus.id_reg_write;
        end
    end

    // Forwarding select: EX/MEM beats MEM/WB, x0 is never forwarded
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_a_val = ex_q.rs1_data;
        fwd_b_sel = 2'b00;
        fwd_b_val = ex_q.rs2_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rs1)) begin
            fwd_a_sel = 2'b10;
            fwd_a_val = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_q.rs1)) begin
            fwd_a_sel = 2'b01;
            fwd_a_val = bus.memwb_result;
        end
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rs2)) begin
            fwd_b_sel = 2'b10;
            fwd_b_val = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_q.rs2)) begin
            fwd_b_sel = 2'b01;
            fwd_b_val = bus.memwb_result;
        end
    end

    // Pipeline register: flush > stall (hold, refresh operands) > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.stall) begin
            // Capture forwarded operands so a producer retiring mid-stall is kept
            ex_q.rs1_data <= fwd_a_val;
            ex_q.rs2_data <= fwd_b_val;
        end else begin
            ex_q <= id_fields;
        end
    end

    // Operand muxes and EX-stage outputs
    always_comb begin
        bus.ex_valid      = ex_q.valid;
        bus.ex_secA       = ex_q.a_pc ? ex_q.pc : fwd_a_val;
        bus.ex_secB       = ex_q.alu_src ? ex_q.imm : fwd_b_val;
        bus.ex_store_data = fwd_b_val;
        bus.ex_alu_ctrl   = ex_q.alu_ctrl;
        bus.ex_rd         = ex_q.rd;
        bus.ex_reg_write  = ex_q.reg_write & ex_q.valid;
        bus.ex_fwd_a      = fwd_a_sel;
        bus.ex_fwd_b      = fwd_b_sel;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX outputs.
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [31:0] seca;
        logic [31:0] secb;
        logic [31:0] store;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    out_t sb[$];

    id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic out_t observe();
        out_t o;
        o.valid = bus.ex_valid;
        o.seca  = bus.ex_secA;
        o.secb  = bus.ex_secB;
        o.store = bus.ex_store_data;
        o.ctrl  = bus.ex_alu_ctrl;
        o.rd    = bus.ex_rd;
        o.rw    = bus.ex_reg_write;
        o.fa    = bus.ex_fwd_a;
        o.fb    = bus.ex_fwd_b;
        return o;
    endfunction

    // Expected EX outputs for an instruction with no forwarding active
    function automatic out_t model(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] r1d, input logic [31:0] r2d,
                                   input logic [4:0] rd, input logic src, input logic apc,
                                   input logic [2:0] ctrl, input logic rw);
        out_t e;
        e = '0;
        if (v) begin
            e.valid = 1'b1;
            e.seca  = apc ? pc : r1d;
            e.secb  = src ? imm : r2d;
            e.store = r2d;
            e.ctrl  = ctrl;
            e.rd    = rd;
            e.rw    = rw;
        end
        return e;
    endfunction

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] r1d, input logic [31:0] r2d,
                            input logic src, input logic apc, input logic [2:0] ctrl,
                            input logic rw);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_imm       = imm;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_rs1_data  = r1d;
        bus.id_rs2_data  = r2d;
        bus.id_alu_src   = src;
        bus.id_a_pc      = apc;
        bus.id_alu_ctrl  = ctrl;
        bus.id_reg_write = rw;
    endtask

    task automatic clear_fwd();
        bus.exmem_rd        = '0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_result    = '0;
        bus.memwb_rd        = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_result    = '0;
    endtask

    task automatic test_reset();
        out_t exp, obs;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_fwd();
        drive_id(1'b1, 32'h100, 32'h5, 5'd5, 5'd6, 5'd7, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 3'b011, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        sb.push_back('0);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state: observed %h expected %h", obs, exp);
        end
        rst_n = 1'b1;
        drive_id(1'b1, 32'h0, 32'h0, 5'd5, 5'd6, 5'd7, 32'h10, 32'h20, 1'b0, 1'b0, 3'b000, 1'b1);
        sb.push_back(model(1'b1, 32'h0, 32'h0, 32'h10, 32'h20, 5'd7, 1'b0, 1'b0, 3'b000, 1'b1));
        @(negedge clk);
        #1;
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL first_add: observed %h expected %h", obs, exp);
        end
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_fwd_priority();
        out_t exp, obs;
        drive_id(1'b1, 32'h200, 32'h0, 5'd3, 5'd4, 5'd8, 32'h1, 32'h2, 1'b0, 1'b0, 3'b001, 1'b1);
        @(negedge clk);
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
        bus.exmem_rd = 5'd3; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hAAAA;
        bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBBBB;
        #1;
        exp = model(1'b1, 32'h200, 32'h0, 32'h1, 32'h2, 5'd8, 1'b0, 1'b0, 3'b001, 1'b1);
        exp.seca = 32'hAAAA;
        exp.fa   = 2'b10;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_exmem_wins: observed %h expected %h", obs, exp);
        end
        bus.exmem_reg_write = 1'b0;
        #1;
        exp.seca = 32'hBBBB;
        exp.fa   = 2'b01;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_memwb: observed %h expected %h", obs, exp);
        end
        clear_fwd();
    endtask

    task automatic test_x0_guard();
        out_t exp, obs;
        drive_id(1'b1, 32'h300, 32'h0, 5'd1, 5'd0, 5'd9, 32'h5, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
        @(negedge clk);
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h1234;
        bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h5678;
        #1;
        sb.push_back(model(1'b1, 32'h300, 32'h0, 32'h5, 32'h0, 5'd9, 1'b0, 1'b0, 3'b010, 1'b1));
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL x0_guard: observed %h expected %h", obs, exp);
        end
        clear_fwd();
    endtask

    task automatic test_imm_pc();
        out_t exp, obs;
        drive_id(1'b1, 32'h400, 32'hFFFFFFF0, 5'd9, 5'd10, 5'd11, 32'h11, 32'h22, 1'b1, 1'b1, 3'b000, 1'b1);
        @(negedge clk);
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
        bus.exmem_rd = 5'd10; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h99;
        bus.memwb_rd = 5'd9;  bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h55;
        #1;
        exp = model(1'b1, 32'h400, 32'hFFFFFFF0, 32'h11, 32'h22, 5'd11, 1'b1, 1'b1, 3'b000, 1'b1);
        exp.store = 32'h99;
        exp.fb    = 2'b10;
        exp.fa    = 2'b01;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL imm_pc_select: observed %h expected %h", obs, exp);
        end
        clear_fwd();
    endtask

    task automatic test_stall_refresh();
        out_t exp, obs;
        drive_id(1'b1, 32'h500, 32'h0, 5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 1'b0, 1'b0, 3'b011, 1'b1);
        @(negedge clk);
        bus.stall = 1'b1;
        drive_id(1'b1, 32'h600, 32'h7, 5'd20, 5'd21, 5'd22, 32'hA, 32'hB, 1'b1, 1'b1, 3'b101, 1'b0);
        bus.memwb_rd = 5'd12; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h77;
        #1;
        exp = model(1'b1, 32'h500, 32'h0, 32'h1, 32'h2, 5'd14, 1'b0, 1'b0, 3'b011, 1'b1);
        exp.seca = 32'h77;
        exp.fa   = 2'b01;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_cycle1: observed %h expected %h", obs, exp);
        end
        @(negedge clk);
        clear_fwd();
        #1;
        exp.fa = 2'b00;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_cycle2: observed %h expected %h", obs, exp);
        end
        @(negedge clk);
        bus.stall = 1'b0;
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
        #1;
        sb.push_back(exp);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_release: observed %h expected %h", obs, exp);
        end
    endtask

    task automatic test_flush_vs_stall();
        out_t exp, obs;
        drive_id(1'b1, 32'h700, 32'h0, 5'd1, 5'd2, 5'd15, 32'h3, 32'h4, 1'b0, 1'b0, 3'b101, 1'b1);
        sb.push_back(model(1'b1, 32'h700, 32'h0, 32'h3, 32'h4, 5'd15, 1'b0, 1'b0, 3'b101, 1'b1));
        @(negedge clk);
        #1;
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pre_flush_load: observed %h expected %h", obs, exp);
        end
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        sb.push_back('0);
        @(negedge clk);
        #1;
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_over_stall: observed %h expected %h", obs, exp);
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_reset_mid_stall();
        out_t exp, obs;
        drive_id(1'b1, 32'h800, 32'h0, 5'd3, 5'd4, 5'd16, 32'h33, 32'h44, 1'b0, 1'b0, 3'b010, 1'b1);
        @(negedge clk);
        bus.stall = 1'b1;
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        sb.push_back('0);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL async_reset_in_stall: observed %h expected %h", obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.stall = 1'b0;
        #1;
        sb.push_back('0);
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL after_reset_stall: observed %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        out_t exp, obs;
        logic        v, src, apc, rw;
        logic [31:0] pc, imm, r1d, r2d;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  ctrl;
        clear_fwd();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                exp = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: observed %h expected %h", i - 1, obs, exp);
                end
            end
            v    = ($urandom_range(0, 3) != 0);
            pc   = $urandom;
            imm  = $urandom;
            r1d  = $urandom;
            r2d  = $urandom;
            rs1  = 5'($urandom_range(0, 31));
            rs2  = 5'($urandom_range(0, 31));
            rd   = 5'($urandom_range(0, 31));
            src  = 1'($urandom_range(0, 1));
            apc  = 1'($urandom_range(0, 1));
            ctrl = 3'($urandom_range(0, 7));
            rw   = 1'($urandom_range(0, 1));
            drive_id(v, pc, imm, rs1, rs2, rd, r1d, r2d, src, apc, ctrl, rw);
            sb.push_back(model(v, pc, imm, r1d, r2d, rd, src, apc, ctrl, rw));
        end
        @(negedge clk);
        #1;
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back[9]: observed %h expected %h", obs, exp);
        end
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_x0_guard();
        test_imm_pc();
        test_stall_refresh();
        test_flush_vs_stall();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
